imiss_refill_ctrl: RTL and testbench
====================================

Name: imiss_refill_ctrl

Overview:
Instruction-miss refill scheduler between the fetch stage and the memory port. It records per-thread I-cache misses and picks one missing line at a time, round-robin across threads. It sequences a multi-beat line read into the I-cache fill port, then reports which threads may resume fetch. Threads that miss on the in-flight line are coalesced, so each line is fetched once.

Parameters:
NTRD, 8, number of hardware threads (thread id width = 3)
LINE_WORDS, 4, 32-bit words per I-cache line (power of 2, 2..16)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
miss_vld  in  1  fetch reports an I-miss this cycle
miss_trd  in  3  thread that missed
miss_pc  in  32  missing pc (word-aligned)
kill_vld  in  1  thread killed; drop its pending miss
kill_trd  in  3  thread being killed
mem_req  out  1  read request to memory
mem_addr  out  32  line-aligned request address
mem_gnt  in  1  memory accepted request
mem_rvld  in  1  one returning data beat
mem_rdata  in  32  beat data
fill_we  out  1  I-cache fill write strobe
fill_addr  out  32  word address being filled
fill_data  out  32  fill word
resolve_vld  out  1  line filled; threads in resolve_mask may refetch
resolve_mask  out  8  threads resolved this cycle
pend_trd  out  8  threads currently waiting on a refill
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (synchronous, rst=1 at posedge): FSM=IDLE, pend_vld=0, served=0, rr_ptr=0, beat_cnt=0. All outputs 0.
- Per-thread table: pend_vld[t], pend_line[t] = miss_pc[31:log2(LINE_WORDS*4)].
- Capture: miss_vld with pend_vld[miss_trd]=0 sets pend_vld and pend_line next cycle. A duplicate miss for an already-pending thread is ignored.
- Kill: clears pend_vld[kill_trd]. Kill and miss for the same thread in the same cycle: kill wins and nothing is recorded. Killing the in-flight thread does not abort the burst; the line still fills, and that thread is excluded from resolve_mask.
- FSM states: IDLE, REQ, DATA, DONE.
- IDLE: if any thread has pend_vld=1 and served=0, pick the first such thread at or after rr_ptr (wrapping 7→0). Latch cur_line, set served for it, go to REQ. rr_ptr becomes the picked thread+1 (mod 8).
- REQ: mem_req=1, mem_addr={cur_line, zeros}. Hold until mem_gnt=1, then go to DATA with beat_cnt=0.
- DATA: on each mem_rvld, drive fill_we=1 combinationally, fill_addr=mem_addr + 4*beat_cnt, fill_data=mem_rdata; beat_cnt increments. The beat with beat_cnt=LINE_WORDS-1 moves to DONE next cycle. mem_rvld outside DATA is ignored.
- DONE (1 cycle): resolve_vld=1, resolve_mask = pend_vld & (pend_line==cur_line), using registered table state. Those bits clear pend_vld and served. Return to IDLE.
- Coalescing: a thread whose miss matches cur_line while the FSM is in REQ or DATA is resolved in DONE without a second fetch. A miss recorded during DONE is not included and is served later.
- served masks picked threads from re-arbitration; it is cleared on resolve or kill.
- Minimum latency from miss capture to resolve: 1 (capture) + 1 (IDLE) + REQ (≥1) + LINE_WORDS beats + 1 (DONE).
- pend_trd = pend_vld; busy = (state != IDLE).
- rst asserted mid-burst returns to IDLE immediately. Any later beats are ignored.

Decomposition:
- Shared package: refill FSM state enum, the LINE_OFF_W = log2(LINE_WORDS*4) constant, and a thread-id typedef (3 bits).
- One sub-module: rr_pick8. It is combinational round-robin priority given an 8-bit request and a 3-bit pointer, returning a grant id and a valid.

Test Plan:
- Single miss: trd=2, pc=0x0000_1234 → mem_addr=0x0000_1230 (LINE_WORDS=4). Beats 0xA..0xD fill 0x1230/34/38/3C. Then resolve_mask=0x04 and pend_trd=0x00.
- Coalesce: trd=1 misses on pc 0x100. During DATA, trd=5 misses on pc 0x108 → one mem_req only, resolve_mask=0x22.
- Round-robin: threads 0, 3 and 6 miss in the same window with different lines, rr_ptr=4 → service order 6, 0, 3. There are three bursts and three single-bit resolves.
- Kill in flight: trd=4 is in DATA and kill_trd=4 arrives → all 4 fill beats are still written, resolve_vld=1 with resolve_mask=0x00.
- Duplicate and collision: a repeat miss from pending trd=2 is ignored (one burst). miss and kill for trd=7 in the same cycle → pend_trd[7] stays 0.
- Reset mid-burst: rst asserted after 2 beats → state=IDLE and pend_trd=0. Remaining mem_rvld beats produce no fill_we.

Source files
------------

// File: rtl/imiss_refill_ctrl_pkg.sv
// Shared types and constants for the instruction-miss refill controller.
package imiss_refill_ctrl_pkg;

    localparam int LINE_WORDS_DEF = 4;

    // Byte-offset width of one I-cache line.
    function automatic int line_off_w(input int words);
        return $clog2(words * 4);
    endfunction

    localparam int LINE_OFF_W = line_off_w(LINE_WORDS_DEF);

    typedef logic [2:0] trd_id_t;

    // Refill FSM state encoding.
    typedef logic [1:0] refill_state_t;
    localparam refill_state_t ST_IDLE = 2'd0;
    localparam refill_state_t ST_REQ  = 2'd1;
    localparam refill_state_t ST_DATA = 2'd2;
    localparam refill_state_t ST_DONE = 2'd3;

endpackage

// File: rtl/imiss_refill_ctrl_rr_pick8.sv
// Combinational round-robin picker: first set request bit at or after ptr, wrapping.
module rr_pick8
    import imiss_refill_ctrl_pkg::*;
(
    input  logic [7:0] req,
    input  trd_id_t    ptr,
    output trd_id_t    gnt_id,
    output logic       gnt_vld
);

    trd_id_t idx;

    always_comb begin
        gnt_id  = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr + 3'(i);
            if (!gnt_vld && req[idx]) begin
                gnt_id  = idx;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/imiss_refill_ctrl.sv
// I-miss refill scheduler: per-thread miss table, round-robin line pick,
// multi-beat fill sequencing and coalesced resolve of all threads on that line.
module imiss_refill_ctrl
    import imiss_refill_ctrl_pkg::*;
#(
    parameter int NTRD       = 8,
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             miss_vld,
    input  trd_id_t          miss_trd,
    input  logic [31:0]      miss_pc,
    input  logic             kill_vld,
    input  trd_id_t          kill_trd,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_gnt,
    input  logic             mem_rvld,
    input  logic [31:0]      mem_rdata,
    output logic             fill_we,
    output logic [31:0]      fill_addr,
    output logic [31:0]      fill_data,
    output logic             resolve_vld,
    output logic [NTRD-1:0]  resolve_mask,
    output logic [NTRD-1:0]  pend_trd,
    output logic             busy
);

    localparam int OFF_W  = line_off_w(LINE_WORDS);
    localparam int LINE_W = 32 - OFF_W;
    localparam int BEAT_W = $clog2(LINE_WORDS);

    refill_state_t     state;
    logic [NTRD-1:0]   pend_vld;
    logic [NTRD-1:0]   served;
    logic [LINE_W-1:0] pend_line [NTRD];
    logic [LINE_W-1:0] cur_line;
    logic [LINE_W-1:0] miss_line;
    trd_id_t           rr_ptr;
    logic [BEAT_W-1:0] beat_cnt;

    logic [NTRD-1:0]   miss_oh;
    logic [NTRD-1:0]   kill_oh;
    logic [NTRD-1:0]   pick_oh;
    logic [NTRD-1:0]   resolve_hit;
    logic [NTRD-1:0]   resolve_clr;
    trd_id_t           pick_id;
    logic              pick_vld;
    logic              pick_fire;
    logic [OFF_W-1:0]  unused_pc_off;

    assign miss_line     = miss_pc[31:OFF_W];
    assign unused_pc_off = miss_pc[OFF_W-1:0];

    rr_pick8 u_pick (
        .req     (pend_vld & ~served),
        .ptr     (rr_ptr),
        .gnt_id  (pick_id),
        .gnt_vld (pick_vld)
    );

    assign pick_fire = (state == ST_IDLE) && pick_vld;

    // Kill beats a same-cycle miss on the same thread; duplicates are dropped.
    always_comb begin
        kill_oh = '0;
        miss_oh = '0;
        pick_oh = '0;
        if (kill_vld)
            kill_oh[kill_trd] = 1'b1;
        if (miss_vld && !pend_vld[miss_trd] && !(kill_vld && (kill_trd == miss_trd)))
            miss_oh[miss_trd] = 1'b1;
        if (pick_fire)
            pick_oh[pick_id] = 1'b1;
    end

    // Every still-pending thread waiting on the in-flight line is resolved together.
    always_comb begin
        resolve_hit = '0;
        for (int t = 0; t < NTRD; t++)
            resolve_hit[t] = pend_vld[t] && (pend_line[t] == cur_line);
    end

    assign resolve_clr = (state == ST_DONE) ? resolve_hit : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            pend_vld <= '0;
            served   <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            pend_vld <= (pend_vld & ~resolve_clr & ~kill_oh) | miss_oh;
            served   <= (served | pick_oh) & ~resolve_clr & ~kill_oh;
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        state  <= ST_REQ;
                        rr_ptr <= pick_id + 3'd1;
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        state    <= ST_DATA;
                        beat_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (mem_rvld) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == BEAT_W'(LINE_WORDS - 1))
                            state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Line tags carry no reset; they are only read when qualified by pend_vld or state.
    always_ff @(posedge clk) begin
        for (int t = 0; t < NTRD; t++)
            if (miss_oh[t])
                pend_line[t] <= miss_line;
        if (pick_fire)
            cur_line <= pend_line[pick_id];
    end

    assign mem_req      = (state == ST_REQ);
    assign mem_addr     = mem_req ? {cur_line, {OFF_W{1'b0}}} : '0;
    assign fill_we      = (state == ST_DATA) && mem_rvld;
    assign fill_addr    = fill_we ? {cur_line, beat_cnt, 2'b00} : '0;
    assign fill_data    = fill_we ? mem_rdata : '0;
    assign resolve_vld  = (state == ST_DONE);
    assign resolve_mask = resolve_clr;
    assign pend_trd     = pend_vld;
    assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_imiss_refill_ctrl.sv
// Directed bench for imiss_refill_ctrl with a transaction-level reference model.
module tb_imiss_refill_ctrl;
    import imiss_refill_ctrl_pkg::*;

    localparam int LW         = 4;
    localparam int LINE_BYTES = 1 << LINE_OFF_W;
    localparam int PH_IDLE    = 0;
    localparam int PH_GRANT   = 1;
    localparam int PH_STREAM  = 2;
    localparam int PH_RESOLVE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_vld;
    logic [2:0]  miss_trd;
    logic [31:0] miss_pc;
    logic        kill_vld;
    logic [2:0]  kill_trd;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvld;
    logic [31:0] mem_rdata;
    logic        fill_we;
    logic [31:0] fill_addr;
    logic [31:0] fill_data;
    logic        resolve_vld;
    logic [7:0]  resolve_mask;
    logic [7:0]  pend_trd;
    logic        busy;

    imiss_refill_ctrl #(.NTRD(8), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst),
        .miss_vld(miss_vld), .miss_trd(miss_trd), .miss_pc(miss_pc),
        .kill_vld(kill_vld), .kill_trd(kill_trd),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvld(mem_rvld), .mem_rdata(mem_rdata),
        .fill_we(fill_we), .fill_addr(fill_addr), .fill_data(fill_data),
        .resolve_vld(resolve_vld), .resolve_mask(resolve_mask),
        .pend_trd(pend_trd), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: thread table, chosen line, beats seen, rotating pointer.
    int          m_phase = PH_IDLE;
    bit          m_pend[8];
    bit          m_served[8];
    int unsigned m_base[8];
    int unsigned m_cur = 0;
    int          m_beats = 0;
    int          m_rr = 0;

    always @(posedge clk) begin : model
        bit old_pend[8];
        bit hit[8];
        int pick;
        if (rst) begin
            m_phase = PH_IDLE;
            m_rr    = 0;
            m_beats = 0;
            for (int t = 0; t < 8; t++) begin
                m_pend[t]   = 1'b0;
                m_served[t] = 1'b0;
            end
        end else begin
            old_pend = m_pend;
            for (int t = 0; t < 8; t++)
                hit[t] = (m_phase == PH_RESOLVE) && m_pend[t] && (m_base[t] == m_cur);
            case (m_phase)
                PH_IDLE: begin
                    pick = -1;
                    for (int k = 0; k < 8; k++)
                        if (pick < 0 && m_pend[(m_rr + k) % 8] && !m_served[(m_rr + k) % 8])
                            pick = (m_rr + k) % 8;
                    if (pick >= 0) begin
                        m_cur = m_base[pick];
                        m_served[pick] = 1'b1;
                        m_rr = (pick + 1) % 8;
                        m_phase = PH_GRANT;
                    end
                end
                PH_GRANT: if (mem_gnt) begin
                    m_phase = PH_STREAM;
                    m_beats = 0;
                end
                PH_STREAM: if (mem_rvld) begin
                    m_beats++;
                    if (m_beats == LW) m_phase = PH_RESOLVE;
                end
                default: m_phase = PH_IDLE;
            endcase
            for (int t = 0; t < 8; t++)
                if (hit[t]) begin
                    m_pend[t]   = 1'b0;
                    m_served[t] = 1'b0;
                end
            if (kill_vld) begin
                m_pend[kill_trd]   = 1'b0;
                m_served[kill_trd] = 1'b0;
            end
            if (miss_vld && !old_pend[miss_trd] && !(kill_vld && kill_trd == miss_trd)) begin
                m_pend[miss_trd] = 1'b1;
                m_base[miss_trd] = miss_pc & ~(LINE_BYTES - 1);
            end
        end
    end

    logic [31:0] req_log[$];
    logic [31:0] fa_log[$];
    logic [31:0] fd_log[$];
    logic [31:0] res_log[$];

    always @(negedge clk) begin : compare
        bit          e_req;
        bit          e_fwe;
        bit          e_rv;
        logic [7:0]  e_mask;
        logic [7:0]  e_pend;
        e_req = (m_phase == PH_GRANT);
        e_fwe = (m_phase == PH_STREAM) && mem_rvld;
        e_rv  = (m_phase == PH_RESOLVE);
        e_mask = '0;
        e_pend = '0;
        for (int t = 0; t < 8; t++) begin
            e_pend[t] = m_pend[t];
            e_mask[t] = e_rv && m_pend[t] && (m_base[t] == m_cur);
        end
        if (chk_en) begin
            check("mem_req",      32'(mem_req),      32'(e_req));
            check("mem_addr",     mem_addr,          e_req ? m_cur : 32'h0);
            check("fill_we",      32'(fill_we),      32'(e_fwe));
            check("fill_addr",    fill_addr,         e_fwe ? 32'(m_cur + 4 * m_beats) : 32'h0);
            check("fill_data",    fill_data,         e_fwe ? mem_rdata : 32'h0);
            check("resolve_vld",  32'(resolve_vld),  32'(e_rv));
            check("resolve_mask", 32'(resolve_mask), 32'(e_mask));
            check("pend_trd",     32'(pend_trd),     32'(e_pend));
            check("busy",         32'(busy),         32'(m_phase != PH_IDLE));
        end
        if (mem_req && mem_gnt) req_log.push_back(mem_addr);
        if (fill_we) begin
            fa_log.push_back(fill_addr);
            fd_log.push_back(fill_data);
        end
        if (resolve_vld) res_log.push_back(32'(resolve_mask));
    end

    // Memory responder: grant one cycle after a request, then stream LW beats.
    bit          resp_en = 1'b1;
    logic [31:0] resp_base = 32'h0;

    initial begin
        mem_gnt = 1'b0; mem_rvld = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (resp_en && mem_req) begin
                mem_gnt = 1'b1;
                @(posedge clk); #1;
                mem_gnt = 1'b0;
                for (int b = 0; b < LW; b++) begin
                    mem_rvld  = 1'b1;
                    mem_rdata = resp_base + 32'(b);
                    @(posedge clk); #1;
                end
                mem_rvld = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_miss(input int t, input logic [31:0] pc);
        miss_vld = 1'b1; miss_trd = 3'(t); miss_pc = pc;
        step(1);
        miss_vld = 1'b0;
    endtask

    task automatic do_kill(input int t);
        kill_vld = 1'b1; kill_trd = 3'(t);
        step(1);
        kill_vld = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        while ((busy || pend_trd != 8'h0) && c < 300) begin
            step(1);
            c++;
        end
        check({name, "_idle_timeout"}, 32'(c < 300), 32'd1);
    endtask

    task automatic wait_fills(input string name, input int n);
        int c = 0;
        while (fa_log.size() < n && c < 300) begin
            step(1);
            c++;
        end
        check({name, "_fill_timeout"}, 32'(c < 300), 32'd1);
    endtask

    task automatic clear_logs();
        req_log.delete(); fa_log.delete(); fd_log.delete(); res_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int nf;
        rst = 1'b1; miss_vld = 1'b0; miss_trd = '0; miss_pc = '0;
        kill_vld = 1'b0; kill_trd = '0;
        step(3);
        check("rst_busy",    32'(busy),         32'd0);
        check("rst_pend",    32'(pend_trd),     32'd0);
        check("rst_mem_req", 32'(mem_req),      32'd0);
        check("rst_fill_we", 32'(fill_we),      32'd0);
        check("rst_resolve", 32'(resolve_vld),  32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        step(1);

        // Single miss
        clear_logs();
        resp_base = 32'hA;
        do_miss(2, 32'h0000_1234);
        wait_idle("t1");
        check("t1_nreq", 32'(req_log.size()), 32'd1);
        check("t1_addr", req_log[0], 32'h0000_1230);
        check("t1_nfill", 32'(fa_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t1_fill_addr", fa_log[i], 32'h0000_1230 + 32'(4 * i));
            check("t1_fill_data", fd_log[i], 32'hA + 32'(i));
        end
        check("t1_res", res_log[0], 32'h04);
        check("t1_pend", 32'(pend_trd), 32'h00);

        // Coalesce a second thread onto the in-flight line
        clear_logs();
        resp_base = 32'h100;
        do_miss(1, 32'h0000_0100);
        wait_fills("t2", 1);
        do_miss(5, 32'h0000_0108);
        wait_idle("t2");
        check("t2_nreq", 32'(req_log.size()), 32'd1);
        check("t2_addr", req_log[0], 32'h0000_0100);
        check("t2_nres", 32'(res_log.size()), 32'd1);
        check("t2_res", res_log[0], 32'h22);

        // Round-robin from pointer 4 behind a blocking burst
        clear_logs();
        resp_en = 1'b0;
        do_miss(3, 32'h0000_3000);
        step(1);
        do_kill(3);
        do_miss(0, 32'h0000_4000);
        do_miss(3, 32'h0000_5000);
        do_miss(6, 32'h0000_6000);
        check("t3_pend", 32'(pend_trd), 32'h49);
        resp_en = 1'b1;
        wait_idle("t3");
        check("t3_nreq", 32'(req_log.size()), 32'd4);
        check("t3_req0", req_log[0], 32'h0000_3000);
        check("t3_req1", req_log[1], 32'h0000_6000);
        check("t3_req2", req_log[2], 32'h0000_4000);
        check("t3_req3", req_log[3], 32'h0000_5000);
        check("t3_res0", res_log[0], 32'h00);
        check("t3_res1", res_log[1], 32'h40);
        check("t3_res2", res_log[2], 32'h01);
        check("t3_res3", res_log[3], 32'h08);

        // Kill of the in-flight thread
        clear_logs();
        do_miss(4, 32'h0000_8000);
        wait_fills("t4", 1);
        do_kill(4);
        wait_idle("t4");
        check("t4_nfill", 32'(fa_log.size()), 32'd4);
        check("t4_fill3", fa_log[3], 32'h0000_800C);
        check("t4_nres", 32'(res_log.size()), 32'd1);
        check("t4_res", res_log[0], 32'h00);

        // Duplicate miss and miss/kill collision
        clear_logs();
        resp_en = 1'b0;
        do_miss(2, 32'h0000_9000);
        do_miss(2, 32'h0000_A000);
        miss_vld = 1'b1; miss_trd = 3'd7; miss_pc = 32'h0000_C000;
        kill_vld = 1'b1; kill_trd = 3'd7;
        step(1);
        miss_vld = 1'b0; kill_vld = 1'b0;
        step(1);
        check("t5_pend", 32'(pend_trd), 32'h04);
        check("t5_busy", 32'(busy), 32'd1);
        resp_en = 1'b1;
        wait_idle("t5");
        check("t5_nreq", 32'(req_log.size()), 32'd1);
        check("t5_addr", req_log[0], 32'h0000_9000);
        check("t5_res", res_log[0], 32'h04);

        // Reset in the middle of a burst
        clear_logs();
        do_miss(1, 32'h0000_B000);
        wait_fills("t6", 2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_pend", 32'(pend_trd), 32'h00);
        nf = fa_log.size();
        step(6);
        check("t6_no_fill", 32'(fa_log.size()), 32'(nf));
        check("t6_idle_req", 32'(mem_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
